// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to the mouse over the
// open-drain clk/data pair. The device generates the PS/2 clock, and this block
// runs entirely on the system clock.
//
// Ports
//   i_clk          system clock, all logic on posedge
//   rst_n          asynchronous active-low reset (releases both lines at once)
//   i_ps2_clk      PS/2 clock line as seen on the pin (asynchronous)
//   i_ps2_data     PS/2 data line as seen on the pin (asynchronous)
//   o_ps2_clk_oe   1 = pull clk line low, 0 = release
//   o_ps2_data_oe  1 = pull data line low, 0 = release
//   i_valid        send request, accepted when i_valid & o_ready
//   i_byte         command byte, latched on acceptance
//   o_ready        high only while idle
//   o_busy         high from acceptance until back in idle (receiver ignores the lines)
//   o_done         1-cycle pulse: frame sent and device ACK seen
//   o_err          1-cycle pulse: missing ACK (or timeout when enabled)
//
// Optional feature: define PS2_TX_TIMEOUT_EN to add a watchdog that starts at
// request-to-send and aborts the transfer after TIMEOUT_CYCLES system clocks.
// Without it the FSM waits for device clocks indefinitely.

module ps2_host_tx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 750000
`endif
) (
    input  logic       i_clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_WAIT_IDLE,
        S_REPORT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;
    logic [8:0]             shreg;      // {parity, byte}, shifted out LSB first
    logic [3:0]             bitcnt;     // device clock falls seen so far (0..10)
    logic [INH_W-1:0]       inh_cnt;
    logic                   ack_err;
`ifdef PS2_TX_TIMEOUT_EN
    logic [TMO_W-1:0]       tmo_cnt;
`endif

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Input synchronizers; idle lines are high, so reset to 1 to avoid a
    // spurious falling edge right after reset.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            o_ps2_clk_oe  <= 1'b0;
            o_ps2_data_oe <= 1'b0;
            o_ready       <= 1'b1;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            shreg         <= '0;
            bitcnt        <= '0;
            inh_cnt       <= '0;
            ack_err       <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_valid && o_ready) begin
                        shreg        <= {~^i_byte, i_byte};
                        bitcnt       <= '0;
                        inh_cnt      <= '0;
                        ack_err      <= 1'b0;
                        o_ps2_clk_oe <= 1'b1;
                        o_ready      <= 1'b0;
                        o_busy       <= 1'b1;
                        state        <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        o_ps2_data_oe <= 1'b1;      // start bit while clk still held
                        state         <= S_RTS;
`ifdef PS2_TX_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                // Release clk one cycle after asserting data so the two
                // open-drain outputs never move together.
                S_RTS: begin
                    o_ps2_clk_oe <= 1'b0;
                    state        <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (fall) begin
                        if (bitcnt == 4'd10) begin
                            // Eleventh fall: device ACK is data pulled low.
                            ack_err <= data_s;
                            state   <= S_WAIT_IDLE;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt <= 4'd8) begin
                                o_ps2_data_oe <= ~shreg[0];
                                shreg         <= {1'b0, shreg[8:1]};
                            end else begin
                                o_ps2_data_oe <= 1'b0;  // stop bit
                            end
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        o_done <= ~ack_err;
                        o_err  <= ack_err;
                        state  <= S_REPORT;
                    end
                end

                // Pulse cycle; ready comes back on the following cycle.
                S_REPORT: begin
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            // Placed after the case so an expiring watchdog overrides any
            // same-cycle clock fall or completion.
            if (state inside {S_RTS, S_SHIFT, S_WAIT_IDLE}) begin
                if (tmo_cnt == TMO_LAST) begin
                    o_ps2_clk_oe  <= 1'b0;
                    o_ps2_data_oe <= 1'b0;
                    o_done        <= 1'b0;
                    o_err         <= 1'b1;
                    state         <= S_REPORT;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 5000;
    localparam int TMO = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       clk_oe, data_oe;
    logic       o_ready, o_busy, o_done, o_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    // Wired-AND open-drain lines with pull-ups.
    assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_err = 0;
    int n_both = 0;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .SYNC_STAGES   (2),
        .INHIBIT_CYCLES(INH)
`ifdef PS2_TX_TIMEOUT_EN
       ,.TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .i_clk        (clk),
        .rst_n        (rst_n),
        .i_ps2_clk    (ps2_clk_line),
        .i_ps2_data   (ps2_data_line),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_data_oe(data_oe),
        .i_valid      (i_valid),
        .i_byte       (i_byte),
        .o_ready      (o_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always @(negedge clk) begin
        if (o_done) n_done++;
        if (o_err) n_err++;
        if (o_done && o_err) n_both++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame as the device should see it: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[0]  = 1'b0;
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_accept(input logic [7:0] b, output bit ok);
        int n;
        n = 0;
        while (!o_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = o_ready;
        i_byte  = b;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_byte  = 8'($urandom);
    endtask

    task automatic inhibit_phase(input bit inject, output int n);
        n = 0;
        while (clk_oe && !data_oe && n < INH + 100) begin
            if (inject && n == 100) begin
                i_valid = 1'b1;
                i_byte  = 8'hA5;
            end
            if (inject && n == 104) i_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        i_valid = 1'b0;
    endtask

    // Device side: waits for request-to-send, then produces nfalls clock
    // pulses with jittered half periods, sampling data on each rising edge.
    task automatic device(input int nfalls, input bit ack, input bit noise,
                          output logic [10:0] got, output bit ok);
        int n;
        got = '0;
        n = 0;
        while (!(clk_oe == 1'b0 && data_oe == 1'b1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 20000);
        if (!ok) return;
        repeat ($urandom_range(15, 25)) @(negedge clk);
        got[0] = ps2_data_line;
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (3) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat ($urandom_range(15, 25)) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) got[k] = ps2_data_line;
            if (k == 11) begin
                if (ack) begin
                    @(negedge clk);
                    dev_data_low = 1'b0;
                end
                return;
            end
            if (noise && k <= 9) begin
                repeat (2) @(negedge clk);
                dev_data_low = 1'b1;
                @(negedge clk);
                dev_data_low = 1'b0;
            end
            repeat ($urandom_range(15, 25)) @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit noise, input bit inject);
        int nd0, ne0, n;
        bit ok;
        logic [10:0] got;
        nd0 = n_done;
        ne0 = n_err;
        send_accept(b, ok);
        check_val("accept", 32'(ok), 1);
        check_val("busy_after_accept", {o_busy, o_ready}, 2'b10);
        inhibit_phase(inject, n);
        check_val("inhibit_len", n, INH);
        check_val("rts_oe", {clk_oe, data_oe}, 2'b11);
        device(11, ack, noise, got, ok);
        check_val("dev_start", 32'(ok), 1);
        check_val($sformatf("frame_%02h", b), got, exp_frame(b));
        n = 0;
        while (!(o_done || o_err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("pulse_seen", 32'(o_done || o_err), 1);
        check_val("ready_at_pulse", o_ready, 0);
        @(negedge clk);
        check_val("ready_after", {o_ready, o_busy, clk_oe, data_oe}, 4'b1000);
        repeat (10) @(negedge clk);
        check_val("no_restart", {o_ready, clk_oe}, 2'b10);
        check_val("done_cnt", n_done - nd0, ack ? 1 : 0);
        check_val("err_cnt", n_err - ne0, ack ? 0 : 1);
    endtask

    task automatic mid_shift_reset();
        int nd0, ne0, n;
        bit ok;
        logic [10:0] got;
        nd0 = n_done;
        ne0 = n_err;
        send_accept(8'h00, ok);
        inhibit_phase(1'b0, n);
        device(4, 1'b0, 1'b0, got, ok);
        check_val("pre_reset_data_oe", {clk_oe, data_oe}, 2'b01);
        #2 rst_n = 1'b0;
        #1 check_val("reset_async_oe", {clk_oe, data_oe}, 2'b00);
        check_val("reset_ready", {o_ready, o_busy}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check_val("post_reset_idle", {o_ready, o_busy, clk_oe, data_oe}, 4'b1000);
        check_val("reset_no_pulse", (n_done - nd0) + (n_err - ne0), 0);
    endtask

    task automatic no_clock_test();
        int n, nd0, ne0;
        bit ok;
        nd0 = n_done;
        ne0 = n_err;
        send_accept(8'h3C, ok);
        inhibit_phase(1'b0, n);
        check_val("tmo_rts", {clk_oe, data_oe}, 2'b11);
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_err && n < TMO + 100);
        check_val("tmo_latency", n, TMO);
        check_val("tmo_released", {clk_oe, data_oe, o_done}, 3'b000);
        @(negedge clk);
        check_val("tmo_idle", {o_ready, o_busy}, 2'b10);
        check_val("tmo_err_cnt", n_err - ne0, 1);
`else
        repeat (3 * TMO) @(negedge clk);
        check_val("stuck_shift", {o_busy, o_ready, clk_oe, data_oe}, 4'b1001);
        check_val("stuck_no_pulse", (n_done - nd0) + (n_err - ne0), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("stuck_recovered", {o_ready, clk_oe, data_oe}, 3'b100);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_state", {o_ready, o_busy, clk_oe, data_oe, o_done, o_err}, 6'b100000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_state", {o_ready, o_busy, clk_oe, data_oe, o_done, o_err}, 6'b100000);

        run_frame(8'hF4, 1'b1, 1'b0, 1'b0);
        run_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        run_frame(8'h00, 1'b1, 1'b0, 1'b1);
        run_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
        end
        mid_shift_reset();
        no_clock_test();

        check_val("done_err_exclusive", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
